// File: rtl/ime_defines.sv
// ime_defines: shared constants and types for the IME SAD partition tree.
//   - Partition slot numbering used on sad_o / min_sad_o / min_idx_o.
//   - npart(): number of partition slots for a given sub-8x8 enable.
//   - sad_w(): partition SAD width derived from the 4x4 SAD width.
//   - ime_state_e: search-run FSM encoding.
package ime_defines;

   localparam int unsigned P16X16     = 0;
   localparam int unsigned P16X8_BASE = 1;
   localparam int unsigned P8X16_BASE = 3;
   localparam int unsigned P8X8_BASE  = 5;
   localparam int unsigned P8X4_BASE  = 9;
   localparam int unsigned P4X8_BASE  = 17;
   localparam int unsigned P4X4_BASE  = 25;
   localparam int unsigned NPART_ALL  = 41;

   function automatic int unsigned npart(input bit en_sub8x8);
      return en_sub8x8 ? NPART_ALL : P8X4_BASE;
   endfunction

   // A 16x16 SAD sums sixteen 4x4 SADs: four extra bits, never overflows.
   function automatic int unsigned sad_w(input int unsigned len);
      return len + 4;
   endfunction

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAcc   = 2'd1,
      StFlush = 2'd2,
      StDone  = 2'd3
   } ime_state_e;

endpackage

// File: rtl/ime_min_cell.sv
// ime_min_cell: running minimum for one partition.
//   clk, rstn      clock, async active-low reset
//   clr_i          restart: minimum to all-ones, index to 0
//   en_i           candidate SAD valid this cycle
//   sad_i, idx_i   candidate SAD and its candidate index
//   min_sad_o      best SAD so far
//   min_idx_o      index of best SAD (earliest wins on ties)
module ime_min_cell
   import ime_defines::*;
#(
   parameter int unsigned SW     = 17,
   parameter int unsigned CAND_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [SW-1:0]     sad_i,
   input  logic [CAND_W-1:0] idx_i,
   output logic [SW-1:0]     min_sad_o,
   output logic [CAND_W-1:0] min_idx_o
);

   logic [SW-1:0]     min_sad_q;
   logic [CAND_W-1:0] min_idx_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         min_sad_q <= '1;
         min_idx_q <= '0;
      end else if (clr_i) begin
         min_sad_q <= '1;
         min_idx_q <= '0;
      end else if (en_i && (sad_i < min_sad_q)) begin
         min_sad_q <= sad_i;
         min_idx_q <= idx_i;
      end
   end

   assign min_sad_o = min_sad_q;
   assign min_idx_o = min_idx_q;

endmodule

// File: rtl/ime_sad_tree_min.sv
// ime_sad_tree_min: builds all H.264 partition SADs from sixteen 4x4 SADs per
// candidate and tracks the per-partition minimum over a start..last search run.
//   clk, rstn     clock, async active-low reset
//   start_i       begin (or restart) a search run
//   sad4x4_v_i    candidate valid; sad4x4_i slot k = block row k/4, col k%4
//   cand_i        candidate index; last_i marks the run's final candidate
//   sad_v_o/sad_o per-candidate partition SADs, two cycles after capture
//   busy_o        run in progress; done_o one-cycle pulse when minima are final
//   min_sad_o/min_idx_o  best SAD and its candidate index per partition
module ime_sad_tree_min
   import ime_defines::*;
#(
   parameter int unsigned  SAD4X4_LEN = 13,
   parameter int unsigned  CAND_W     = 10,
   parameter bit           EN_SUB8X8  = 1'b1,
   localparam int unsigned SW         = sad_w(SAD4X4_LEN),
   localparam int unsigned NPART      = npart(EN_SUB8X8)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start_i,
   input  logic                      sad4x4_v_i,
   input  logic [16*SAD4X4_LEN-1:0]  sad4x4_i,
   input  logic [CAND_W-1:0]         cand_i,
   input  logic                      last_i,
   output logic                      sad_v_o,
   output logic [NPART*SW-1:0]       sad_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [NPART*SW-1:0]       min_sad_o,
   output logic [NPART*CAND_W-1:0]   min_idx_o
);

   localparam int unsigned L  = SAD4X4_LEN;
   localparam int unsigned W1 = L + 1;
   localparam int unsigned W2 = L + 2;
   localparam int unsigned W3 = L + 3;

   ime_state_e state_q, state_d;
   logic       accept;

   logic              in_v_q, s1_v_q, s2_v_q, s3_last_q;
   logic              in_last_q, s1_last_q, s2_last_q;
   logic [CAND_W-1:0] in_cand_q, s1_cand_q, s2_cand_q;

   logic [L-1:0]  in_sad_q  [16];
   logic [W2-1:0] s1_8x8_d  [4];
   logic [W2-1:0] s1_8x8_q  [4];
   logic [W1-1:0] s1_8x4_q  [8];
   logic [W1-1:0] s1_4x8_q  [8];
   logic [L-1:0]  s1_4x4_q  [16];
   logic [SW-1:0] sad_full  [NPART_ALL];
   logic [SW-1:0] sad_q     [NPART];

   // A start always wins: same-cycle candidates are dropped.
   assign accept = (state_q == StAcc) && sad4x4_v_i && !start_i;

   always_comb begin
      state_d = state_q;
      if (start_i) begin
         state_d = StAcc;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StIdle;
            StAcc:   if (accept && last_i) state_d = StFlush;
            StFlush: if (s3_last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Valid pipeline; a start aborts everything in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_v_q    <= 1'b0;
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         s3_last_q <= 1'b0;
      end else if (start_i) begin
         in_v_q    <= 1'b0;
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         s3_last_q <= 1'b0;
      end else begin
         in_v_q    <= accept;
         s1_v_q    <= in_v_q;
         s2_v_q    <= s1_v_q;
         s3_last_q <= s2_v_q & s2_last_q;
      end
   end

   // Input capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 16; k++) in_sad_q[k] <= '0;
         in_cand_q <= '0;
         in_last_q <= 1'b0;
      end else if (accept) begin
         for (int k = 0; k < 16; k++) in_sad_q[k] <= sad4x4_i[k*L +: L];
         in_cand_q <= cand_i;
         in_last_q <= last_i;
      end
   end

   // S1: 8x8 quads, top-left 4x4 block of quad i sits at row 2*(i/2), col 2*(i%2).
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         s1_8x8_d[i] = W2'(in_sad_q[8*(i/2) + 2*(i%2)])
                     + W2'(in_sad_q[8*(i/2) + 2*(i%2) + 1])
                     + W2'(in_sad_q[8*(i/2) + 2*(i%2) + 4])
                     + W2'(in_sad_q[8*(i/2) + 2*(i%2) + 5]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 4; i++) s1_8x8_q[i] <= '0;
         s1_cand_q <= '0;
         s1_last_q <= 1'b0;
      end else if (in_v_q) begin
         for (int i = 0; i < 4; i++) s1_8x8_q[i] <= s1_8x8_d[i];
         s1_cand_q <= in_cand_q;
         s1_last_q <= in_last_q;
      end
   end

   if (EN_SUB8X8) begin : g_sub8
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
               s1_8x4_q[i] <= '0;
               s1_4x8_q[i] <= '0;
            end
            for (int k = 0; k < 16; k++) s1_4x4_q[k] <= '0;
         end else if (in_v_q) begin
            // 8x4: 2 wide x 4 tall grid; 4x8: 4 wide x 2 tall grid.
            for (int i = 0; i < 8; i++) begin
               s1_8x4_q[i] <= W1'(in_sad_q[4*(i/2) + 2*(i%2)])
                            + W1'(in_sad_q[4*(i/2) + 2*(i%2) + 1]);
               s1_4x8_q[i] <= W1'(in_sad_q[8*(i/4) + (i%4)])
                            + W1'(in_sad_q[8*(i/4) + (i%4) + 4]);
            end
            for (int k = 0; k < 16; k++) s1_4x4_q[k] <= in_sad_q[k];
         end
      end
   end else begin : g_no_sub8
      always_comb begin
         for (int i = 0; i < 8; i++) begin
            s1_8x4_q[i] = '0;
            s1_4x8_q[i] = '0;
         end
         for (int k = 0; k < 16; k++) s1_4x4_q[k] = '0;
      end
   end

   // S2 next values for every slot; only the first NPART are registered.
   always_comb begin
      for (int p = 0; p < NPART_ALL; p++) sad_full[p] = '0;
      sad_full[P16X16]       = SW'(s1_8x8_q[0]) + SW'(s1_8x8_q[1])
                             + SW'(s1_8x8_q[2]) + SW'(s1_8x8_q[3]);
      sad_full[P16X8_BASE]   = SW'(W3'(s1_8x8_q[0]) + W3'(s1_8x8_q[1]));
      sad_full[P16X8_BASE+1] = SW'(W3'(s1_8x8_q[2]) + W3'(s1_8x8_q[3]));
      sad_full[P8X16_BASE]   = SW'(W3'(s1_8x8_q[0]) + W3'(s1_8x8_q[2]));
      sad_full[P8X16_BASE+1] = SW'(W3'(s1_8x8_q[1]) + W3'(s1_8x8_q[3]));
      for (int i = 0; i < 4; i++)  sad_full[P8X8_BASE+i] = SW'(s1_8x8_q[i]);
      for (int i = 0; i < 8; i++)  sad_full[P8X4_BASE+i] = SW'(s1_8x4_q[i]);
      for (int i = 0; i < 8; i++)  sad_full[P4X8_BASE+i] = SW'(s1_4x8_q[i]);
      for (int k = 0; k < 16; k++) sad_full[P4X4_BASE+k] = SW'(s1_4x4_q[k]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int p = 0; p < NPART; p++) sad_q[p] <= '0;
         s2_cand_q <= '0;
         s2_last_q <= 1'b0;
      end else if (s1_v_q) begin
         for (int p = 0; p < NPART; p++) sad_q[p] <= sad_full[p];
         s2_cand_q <= s1_cand_q;
         s2_last_q <= s1_last_q;
      end
   end

   // S3: per-partition minima.
   for (genvar p = 0; p < NPART; p++) begin : g_min
      ime_min_cell #(
         .SW     (SW),
         .CAND_W (CAND_W)
      ) u_min_cell (
         .clk       (clk),
         .rstn      (rstn),
         .clr_i     (start_i),
         .en_i      (s2_v_q),
         .sad_i     (sad_q[p]),
         .idx_i     (s2_cand_q),
         .min_sad_o (min_sad_o[p*SW +: SW]),
         .min_idx_o (min_idx_o[p*CAND_W +: CAND_W])
      );
      assign sad_o[p*SW +: SW] = sad_q[p];
   end

   assign sad_v_o = s2_v_q;
   assign busy_o  = (state_q != StIdle);
   assign done_o  = (state_q == StDone);

endmodule

// File: tb/tb_ime_sad_tree_min.sv
// tb_ime_sad_tree_min: random and directed stimulus for ime_sad_tree_min with a
// geometric partition model; checks a full (41-slot) and a reduced (9-slot) build.
module tb_ime_sad_tree_min;

   localparam int unsigned LEN = 13;
   localparam int unsigned CW  = 10;
   localparam int unsigned SW  = 17;
   localparam int unsigned NP  = 41;
   localparam int unsigned NP2 = 9;

   logic clk = 1'b0;
   logic rstn;
   logic start_i, v_i, last_i;
   logic [16*LEN-1:0] sad4x4_i;
   logic [CW-1:0]     cand_i;

   logic              sad_v_o, busy_o, done_o;
   logic [NP*SW-1:0]  sad_o, min_sad_o;
   logic [NP*CW-1:0]  min_idx_o;
   logic              sad_v2, busy2, done2;
   logic [NP2*SW-1:0] sad2, min_sad2;
   logic [NP2*CW-1:0] min_idx2;

   always #5 clk = ~clk;

   ime_sad_tree_min #(.SAD4X4_LEN(LEN), .CAND_W(CW), .EN_SUB8X8(1'b1)) u_dut (
      .clk(clk), .rstn(rstn), .start_i(start_i), .sad4x4_v_i(v_i), .sad4x4_i(sad4x4_i),
      .cand_i(cand_i), .last_i(last_i), .sad_v_o(sad_v_o), .sad_o(sad_o), .busy_o(busy_o),
      .done_o(done_o), .min_sad_o(min_sad_o), .min_idx_o(min_idx_o)
   );

   ime_sad_tree_min #(.SAD4X4_LEN(LEN), .CAND_W(CW), .EN_SUB8X8(1'b0)) u_dut_small (
      .clk(clk), .rstn(rstn), .start_i(start_i), .sad4x4_v_i(v_i), .sad4x4_i(sad4x4_i),
      .cand_i(cand_i), .last_i(last_i), .sad_v_o(sad_v2), .sad_o(sad2), .busy_o(busy2),
      .done_o(done2), .min_sad_o(min_sad2), .min_idx_o(min_idx2)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [719:0] got, input logic [719:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state.
   typedef struct {
      int               due;
      logic [NP*SW-1:0] sads;
   } exp_t;

   int unsigned vals [16];
   int unsigned mmin [NP];
   int unsigned midx [NP];
   exp_t        q [$];
   int          cyc = 0;
   int          done_due = -1;
   bit          running = 0;
   bit          accepting = 0;

   // Partition SAD from its rectangle of 4x4 blocks (row, col, height, width).
   function automatic int unsigned part_sad(input int slot);
      int r0, c0, h, w, i;
      int unsigned s;
      if (slot == 0) begin r0 = 0; c0 = 0; h = 4; w = 4; end
      else if (slot < 3) begin i = slot - 1; r0 = 2*i; c0 = 0; h = 2; w = 4; end
      else if (slot < 5) begin i = slot - 3; r0 = 0; c0 = 2*i; h = 4; w = 2; end
      else if (slot < 9) begin i = slot - 5; r0 = 2*(i/2); c0 = 2*(i%2); h = 2; w = 2; end
      else if (slot < 17) begin i = slot - 9; r0 = i/2; c0 = 2*(i%2); h = 1; w = 2; end
      else if (slot < 25) begin i = slot - 17; r0 = 2*(i/4); c0 = i%4; h = 2; w = 1; end
      else begin i = slot - 25; r0 = i/4; c0 = i%4; h = 1; w = 1; end
      s = 0;
      for (int r = r0; r < r0 + h; r++)
         for (int c = c0; c < c0 + w; c++)
            s += vals[r*4 + c];
      return s;
   endfunction

   task automatic clear_model_min();
      for (int p = 0; p < NP; p++) begin
         mmin[p] = (1 << SW) - 1;
         midx[p] = 0;
      end
   endtask

   task automatic model_edge();
      exp_t e;
      exp_t nq [$];
      int unsigned sv;
      cyc++;
      if (start_i) begin
         running = 1; accepting = 1; done_due = -1;
         clear_model_min();
         foreach (q[i]) if (q[i].due < cyc) nq.push_back(q[i]);
         q = nq;
      end else begin
         if (accepting && v_i) begin
            e.due = cyc + 2;
            e.sads = '0;
            for (int p = 0; p < NP; p++) begin
               sv = part_sad(p);
               e.sads[p*SW +: SW] = SW'(sv);
               if (sv < mmin[p]) begin
                  mmin[p] = sv;
                  midx[p] = cand_i;
               end
            end
            q.push_back(e);
            if (last_i) begin
               accepting = 0;
               done_due = cyc + 4;
            end
         end
         if (done_due >= 0 && cyc == done_due + 1) running = 0;
      end
   endtask

   task automatic check_outputs();
      bit ev;
      logic [NP*SW-1:0] em;
      logic [NP*CW-1:0] ei;
      ev = (q.size() > 0) && (q[0].due == cyc);
      check_eq($sformatf("sad_v@%0d", cyc), sad_v_o, ev);
      check_eq($sformatf("sad_v_small@%0d", cyc), sad_v2, ev);
      if (ev) begin
         check_eq($sformatf("sad@%0d", cyc), sad_o, q[0].sads);
         check_eq($sformatf("sad_small@%0d", cyc), sad2, q[0].sads[NP2*SW-1:0]);
         void'(q.pop_front());
      end
      check_eq($sformatf("done@%0d", cyc), done_o, cyc == done_due);
      check_eq($sformatf("done_small@%0d", cyc), done2, cyc == done_due);
      check_eq($sformatf("busy@%0d", cyc), busy_o, running);
      check_eq($sformatf("busy_small@%0d", cyc), busy2, running);
      if (cyc == done_due) begin
         for (int p = 0; p < NP; p++) begin
            em[p*SW +: SW] = SW'(mmin[p]);
            ei[p*CW +: CW] = CW'(midx[p]);
         end
         check_eq($sformatf("min_sad@%0d", cyc), min_sad_o, em);
         check_eq($sformatf("min_idx@%0d", cyc), min_idx_o, ei);
         check_eq($sformatf("min_sad_small@%0d", cyc), min_sad2, em[NP2*SW-1:0]);
         check_eq($sformatf("min_idx_small@%0d", cyc), min_idx2, ei[NP2*CW-1:0]);
      end
   endtask

   task automatic cycle();
      for (int k = 0; k < 16; k++) sad4x4_i[k*LEN +: LEN] = LEN'(vals[k]);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_all(input int unsigned x);
      for (int k = 0; k < 16; k++) vals[k] = x;
   endtask

   task automatic rand_vals(input bit tie);
      for (int k = 0; k < 16; k++) vals[k] = tie ? $urandom_range(0, 3) : $urandom_range(0, 8191);
   endtask

   task automatic do_start(input bit with_v);
      start_i = 1'b1; v_i = with_v; last_i = 1'b0;
      cycle();
      start_i = 1'b0; v_i = 1'b0;
   endtask

   task automatic send(input int unsigned cand, input bit last);
      cand_i = CW'(cand); v_i = 1'b1; last_i = last;
      cycle();
      v_i = 1'b0; last_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic check_reset_values();
      check_eq("rst_sad_v", sad_v_o, 1'b0);
      check_eq("rst_sad", sad_o, '0);
      check_eq("rst_done", done_o, 1'b0);
      check_eq("rst_busy", busy_o, 1'b0);
      check_eq("rst_min_sad", min_sad_o, {NP*SW{1'b1}});
      check_eq("rst_min_idx", min_idx_o, '0);
      check_eq("rst_min_sad_small", min_sad2, {NP2*SW{1'b1}});
      check_eq("rst_sad_small", sad2, '0);
   endtask

   task automatic model_reset();
      q.delete(); running = 0; accepting = 0; done_due = -1;
      clear_model_min();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; start_i = 1'b0; v_i = 1'b0; last_i = 1'b0; cand_i = '0;
      set_all(0);
      sad4x4_i = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values();
      rstn = 1'b1;

      // Valid without start is ignored.
      set_all(4); cand_i = 3; v_i = 1'b1;
      idle(3);
      v_i = 1'b0;
      check_eq("idle_min_sad", min_sad_o, {NP*SW{1'b1}});

      // Single candidate, all ones.
      do_start(1'b0);
      set_all(1); send(5, 1'b1); idle(6);
      check_eq("t2_16x16", min_sad_o[0*SW +: SW], 17'd16);
      check_eq("t2_16x8", min_sad_o[2*SW +: SW], 17'd8);
      check_eq("t2_8x16", min_sad_o[3*SW +: SW], 17'd8);
      check_eq("t2_8x8", min_sad_o[5*SW +: SW], 17'd4);
      check_eq("t2_8x4", min_sad_o[9*SW +: SW], 17'd2);
      check_eq("t2_4x8", min_sad_o[24*SW +: SW], 17'd2);
      check_eq("t2_4x4", min_sad_o[40*SW +: SW], 17'd1);
      check_eq("t2_idx", min_idx_o, {NP{10'd5}});

      // Three back-to-back candidates, tie on 4x4 slot 0.
      do_start(1'b0);
      set_all(7); vals[0] = 9; send(0, 1'b0);
      set_all(7); vals[0] = 3; send(1, 1'b0);
      set_all(2); vals[0] = 3; send(2, 1'b1);
      idle(6);
      check_eq("t3_4x4_0", min_sad_o[25*SW +: SW], 17'd3);
      check_eq("t3_4x4_0_idx", min_idx_o[25*CW +: CW], 10'd1);
      check_eq("t3_16x16", min_sad_o[0*SW +: SW], 17'd33);
      check_eq("t3_16x16_idx", min_idx_o[0*CW +: CW], 10'd2);

      // Maximum input values.
      do_start(1'b0);
      set_all(8191); send(11, 1'b1); idle(6);
      check_eq("t4_16x16", min_sad_o[0*SW +: SW], 17'd131056);
      check_eq("t4_8x8", min_sad_o[5*SW +: SW], 17'd32764);

      // Abort mid-run (with a dropped same-cycle candidate), then a one-candidate run.
      do_start(1'b0);
      rand_vals(1'b0); send(1, 1'b0);
      rand_vals(1'b0); send(2, 1'b0);
      set_all(0); cand_i = 9;
      do_start(1'b1);
      set_all(2); send(7, 1'b1); idle(6);
      check_eq("t5_16x16", min_sad_o[0*SW +: SW], 17'd32);
      check_eq("t5_idx", min_idx_o[0*CW +: CW], 10'd7);

      // Start with valid in IDLE: candidate dropped.
      set_all(0); cand_i = 4;
      do_start(1'b1);
      set_all(3); send(6, 1'b1); idle(6);
      check_eq("t6_small_16x16", min_sad2[0*SW +: SW], 17'd48);
      check_eq("t6_small_8x16", min_sad2[3*SW +: SW], 17'd24);
      check_eq("t6_small_8x8", min_sad2[5*SW +: SW], 17'd12);

      // Randomised runs with gaps, stray controls and occasional aborts.
      for (int r = 0; r < 30; r++) begin
         int n, budget;
         bit tie;
         tie = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 6);
         rand_vals(tie);
         do_start(1'($urandom_range(0, 1)));
         for (int c = 0; c < n; c++) begin
            while ($urandom_range(0, 3) == 0) begin
               v_i = 1'b0; last_i = 1'($urandom_range(0, 1));
               cycle();
            end
            rand_vals(tie);
            if (c > 0 && c < n - 1 && $urandom_range(0, 7) == 0) start_i = 1'b1;
            send($urandom_range(0, 1023), c == n - 1);
            start_i = 1'b0;
         end
         budget = 0;
         while (running && budget < 20) begin
            v_i = 1'($urandom_range(0, 1)); last_i = 1'($urandom_range(0, 1));
            rand_vals(tie);
            cycle();
            budget++;
         end
         v_i = 1'b0; last_i = 1'b0;
         check_eq($sformatf("run%0d_idle", r), busy_o, 1'b0);
      end

      // Reset in the middle of a run.
      do_start(1'b0);
      rand_vals(1'b0); send(3, 1'b0);
      rand_vals(1'b0); send(4, 1'b0);
      rstn = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ime_sad_tree_min.md
Name: ime_sad_tree_min

Overview:
- Parametrised successor to the 4x4-to-8x8 SAD combiner in the IME datapath.
- Per search candidate, it takes 16 packed 4x4 SADs and builds every H.264 partition SAD up to 16x16 in a pipelined adder tree.
- Over a search run delimited by start/last, it tracks the minimum SAD and the winning candidate index per partition.
- Sits between the 4x4 SAD array and the IME mode-decision/cost stage.

Parameters:
- SAD4X4_LEN, 13, bit width of one input 4x4 SAD.
- CAND_W, 10, candidate index width.
- EN_SUB8X8, 1, 1 = all 41 partitions (16x16 down to 4x4); 0 = only 9 partitions (16x16, 16x8, 8x16, 8x8).
- Derived: SW = SAD4X4_LEN+4; NPART = EN_SUB8X8 ? 41 : 9.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: begin a new search run
- sad4x4_v_i  in  1  candidate SAD set valid
- sad4x4_i  in  16*SAD4X4_LEN  4x4 SADs; slot k = block row k/4, col k%4
- cand_i  in  CAND_W  index of this candidate
- last_i  in  1  qualifies sad4x4_v_i: final candidate of the run
- sad_v_o  out  1  per-candidate partition SADs valid
- sad_o  out  NPART*SW  per-candidate partition SADs, zero-extended
- busy_o  out  1  run in progress (state != IDLE)
- done_o  out  1  one-cycle pulse: minima final
- min_sad_o  out  NPART*SW  best SAD per partition
- min_idx_o  out  NPART*CAND_W  cand_i of best SAD per partition

Behaviour:
Reset: all outputs 0, FSM=IDLE, pipeline valids 0, min_sad_o all-ones.

Partition slot order:
- 0: 16x16
- 1–2: 16x8 top, bottom
- 3–4: 8x16 left, right
- 5–8: 8x8 raster
- 9–16: 8x4 raster (2 wide × 4 tall)
- 17–24: 4x8 raster (4 wide × 2 tall)
- 25–40: 4x4 raster

Pipeline:
- Stage S1 registers 8x4, 4x8, 8x8 and a 4x4 copy.
- Stage S2 registers 16x8, 8x16, 16x16, and forwards S1 results.
- Stage S3 updates the minima.
- Widths: 8x4/4x8 = LEN+1, 8x8 = LEN+2, 16x8/8x16 = LEN+3, 16x16 = LEN+4. Unsigned, no saturation, no overflow possible.

Latency (input sampled at edge N):
- sad_o / sad_v_o valid after edge N+2, for one cycle per candidate.
- Minima include that candidate after edge N+3.
- Full throughput: one candidate per cycle.

FSM:
- IDLE: start_i -> ACC. On that edge, clear min_sad_o to all-ones and min_idx_o to 0.
- ACC: sad4x4_v_i accepted. sad4x4_v_i & last_i -> FLUSH.
- FLUSH: further sad4x4_v_i ignored. When the last candidate's S3 update completes -> DONE.
- DONE: done_o=1 for exactly one cycle -> IDLE. Minima hold until the next start_i.

Update rule:
- Per partition, new < current min -> replace SAD and index.
- Strict less-than: on a tie the earlier candidate wins.

Boundaries:
- sad4x4_v_i in IDLE, FLUSH or DONE: ignored; no sad_v_o generated.
- start_i in any non-IDLE state: abort. All pipeline valids are cleared in the same edge and minima re-cleared -> ACC. Any same-cycle sad4x4_v_i is dropped.
- start_i and sad4x4_v_i together in IDLE: start wins; the candidate is dropped.
- last_i without sad4x4_v_i: ignored.
- Run with a single candidate (valid & last in its first ACC cycle): done_o after edge N+4.
- rstn asserted mid-run: immediate return to reset values; no done_o.
- EN_SUB8X8=0: 8x4/4x8/4x4 logic is not generated.

Decomposition:
- ime_defines package holds:
  - partition slot constants (P16X16=0 … P4X4_BASE=25);
  - NPART formula;
  - SW derivation;
  - FSM state encoding (IDLE/ACC/FLUSH/DONE).
- One sub-module, ime_min_cell: a single-partition compare/update register (SAD + index, clear, en). Instantiated NPART times in a generate loop.

Test Plan:
1. Reset then idle -> all outputs 0, min_sad_o all-ones, busy_o=0; sad4x4_v_i=1 with no start -> no sad_v_o.
2. start, one candidate cand=5 with all 4x4=1 and last=1 -> sad_o: 16x16=16, 16x8=8, 8x8=4, 8x4=2, 4x4=1. done_o after edge N+4; every min_idx=5.
3. start, cand 0..2 back-to-back, 4x4 slot0 = 9,3,3 and others = 7,7,2 -> min 4x4[0]=3 idx 1 (tie keeps 1); 16x16 min = 33 idx 2 (cand0=114, cand1=108).
4. All 4x4 = 8191 -> 16x16=131056 exactly, 8x8=32764; no wrap.
5. start, two candidates streamed (no last), then start again, then one candidate cand=7 SAD all 2 with last -> minima reflect only cand 7 (16x16=32); exactly one done_o.
6. EN_SUB8X8=0: sad_o width 9*SW; single candidate all 4x4=3 -> 16x16=48, 8x16=24, 8x8=12.
